mac_tx_frame_reader: RTL

- Downstream consumer of the switch egress post stage, in the per-port interface clock domain.
- Pops one frame descriptor from the pointer FIFO: bits [15:12] = source port, bits [11:0] = frame byte count.
- Reads exactly that many bytes from the byte data FIFO and transmits them on GMII, preceded by preamble/SFD and followed by an inter-frame gap.
- Discards, without transmitting, descriptors whose length is out of range, and keeps frame/drop/error statistics.

---
 rtl/mac_tx_frame_reader.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/mac_tx_frame_reader.sv
// mac_tx_frame_reader: pops frame descriptors, streams the matching bytes out on GMII
// with preamble/SFD and inter-frame gap, drains and drops descriptors whose length
// is out of range, and keeps frame/drop/underrun statistics.
module mac_tx_frame_reader #(
  parameter int MIN_LEN = 60,
  parameter int MAX_LEN = 1518,
  parameter int IFG_LEN = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_enable,
  output logic        ptr_fifo_rd,
  input  logic [15:0] ptr_fifo_dout,
  input  logic        ptr_fifo_empty,
  output logic        data_fifo_rd,
  input  logic [7:0]  data_fifo_dout,
  input  logic        data_fifo_empty,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic        tx_busy,
  output logic [3:0]  last_src_port,
  output logic [15:0] tx_frame_cnt,
  output logic [15:0] tx_drop_cnt,
  output logic [15:0] tx_err_cnt
);

  // An IFG shorter than one cycle would let frames touch, so clamp it.
  localparam int          IFG_EFF   = (IFG_LEN < 1) ? 1 : IFG_LEN;
  localparam logic [15:0] IFG_LAST  = 16'(IFG_EFF - 1);
  localparam logic [11:0] MIN_LEN_W = 12'(MIN_LEN);
  localparam logic [11:0] MAX_LEN_W = 12'(MAX_LEN);
  localparam logic [7:0]  PRE_BYTE  = 8'h55;
  localparam logic [7:0]  SFD_BYTE  = 8'hD5;

  typedef enum logic [2:0] {
    IDLE,
    PTR_WAIT,
    CHECK,
    PREAMBLE,
    DATA,
    DROP,
    IFG
  } state_t;

  state_t      state;
  logic [11:0] frame_len;
  logic [11:0] rd_cnt;
  logic [11:0] byte_cnt;
  logic [2:0]  pre_cnt;
  logic [15:0] ifg_cnt;
  logic        underrun;
  logic        rd_d1;
  logic        read_due;
  logic        len_ok;
  logic [11:0] desc_len;

  assign desc_len = ptr_fifo_dout[11:0];
  assign len_ok   = (desc_len >= MIN_LEN_W) && (desc_len <= MAX_LEN_W);
  assign tx_busy  = (state != IDLE);

  // A byte read slot is due while fewer than len slots have been used; on transmit the
  // reads start two cycles before the first data slot so byte 0 follows the SFD directly.
  always_comb begin
    read_due = 1'b0;
    case (state)
      PREAMBLE: read_due = (pre_cnt >= 3'd6) && (rd_cnt < frame_len);
      DATA:     read_due = (rd_cnt < frame_len);
      DROP:     read_due = (rd_cnt < frame_len);
      default:  read_due = 1'b0;
    endcase
  end

  // The pop is gated by the live empty flag so a slot that finds the FIFO empty is never
  // read; once a frame has underrun, every later slot of that frame is left unread.
  assign data_fifo_rd = read_due && !data_fifo_empty && !underrun;

  // Main controller: sequencing, registered GMII outputs and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr_fifo_rd   <= 1'b0;
      gmii_txd      <= 8'h00;
      gmii_tx_en    <= 1'b0;
      gmii_tx_er    <= 1'b0;
      last_src_port <= 4'h0;
      tx_frame_cnt  <= 16'h0000;
      tx_drop_cnt   <= 16'h0000;
      tx_err_cnt    <= 16'h0000;
      frame_len     <= 12'h000;
      rd_cnt        <= 12'h000;
      byte_cnt      <= 12'h000;
      pre_cnt       <= 3'd0;
      ifg_cnt       <= 16'h0000;
      underrun      <= 1'b0;
      rd_d1         <= 1'b0;
    end else begin
      ptr_fifo_rd <= 1'b0;
      rd_d1       <= data_fifo_rd;

      case (state)
        IDLE: begin
          gmii_txd   <= 8'h00;
          gmii_tx_en <= 1'b0;
          gmii_tx_er <= 1'b0;
          if (!ptr_fifo_empty && tx_enable) begin
            ptr_fifo_rd <= 1'b1;
            state       <= PTR_WAIT;
          end
        end

        PTR_WAIT: begin
          state <= CHECK;
        end

        CHECK: begin
          frame_len     <= desc_len;
          last_src_port <= ptr_fifo_dout[15:12];
          rd_cnt        <= 12'h000;
          byte_cnt      <= 12'h000;
          pre_cnt       <= 3'd0;
          underrun      <= 1'b0;
          if (len_ok) begin
            gmii_tx_en <= 1'b1;
            gmii_tx_er <= 1'b0;
            gmii_txd   <= PRE_BYTE;
            state      <= PREAMBLE;
          end else begin
            state <= DROP;
          end
        end

        PREAMBLE: begin
          pre_cnt <= pre_cnt + 3'd1;
          if (read_due) begin
            rd_cnt <= rd_cnt + 12'd1;
            if (data_fifo_empty) begin
              underrun <= 1'b1;
            end
          end
          if (pre_cnt == 3'd6) begin
            gmii_txd <= SFD_BYTE;
          end else if (pre_cnt == 3'd7) begin
            if (frame_len == 12'h000) begin
              gmii_txd     <= 8'h00;
              gmii_tx_en   <= 1'b0;
              gmii_tx_er   <= 1'b0;
              ifg_cnt      <= 16'h0000;
              tx_frame_cnt <= tx_frame_cnt + 16'd1;
              state        <= IFG;
            end else begin
              gmii_txd   <= rd_d1 ? data_fifo_dout : 8'h00;
              gmii_tx_er <= !rd_d1;
              byte_cnt   <= 12'd1;
              state      <= DATA;
            end
          end
        end

        DATA: begin
          if (read_due) begin
            rd_cnt <= rd_cnt + 12'd1;
            if (data_fifo_empty) begin
              underrun <= 1'b1;
            end
          end
          if (byte_cnt == frame_len) begin
            gmii_txd   <= 8'h00;
            gmii_tx_en <= 1'b0;
            gmii_tx_er <= 1'b0;
            ifg_cnt    <= 16'h0000;
            state      <= IFG;
            if (underrun) begin
              tx_err_cnt <= tx_err_cnt + 16'd1;
            end else begin
              tx_frame_cnt <= tx_frame_cnt + 16'd1;
            end
          end else begin
            gmii_txd   <= rd_d1 ? data_fifo_dout : 8'h00;
            gmii_tx_er <= !rd_d1;
            byte_cnt   <= byte_cnt + 12'd1;
          end
        end

        DROP: begin
          if (rd_cnt == frame_len) begin
            tx_drop_cnt <= tx_drop_cnt + 16'd1;
            state       <= IDLE;
          end else if (data_fifo_rd) begin
            rd_cnt <= rd_cnt + 12'd1;
          end
        end

        IFG: begin
          gmii_txd   <= 8'h00;
          gmii_tx_en <= 1'b0;
          gmii_tx_er <= 1'b0;
          if (ifg_cnt == IFG_LAST) begin
            state <= IDLE;
          end else begin
            ifg_cnt <= ifg_cnt + 16'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
